// File: rtl/bram_capture_reader_pkg.sv
// Shared constants and state encoding for the FIR capture/playback path.
package bram_capture_reader_pkg;

  localparam int NB_ADDR_DEF = 11;
  localparam int NB_DATA_DEF = 13;
  // Same sample count the capture writer fills before raising mem_full.
  localparam int MAX_COUNT   = 2047;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/bram_capture_reader_skid_fifo2.sv
// Two-entry fall-through FIFO: a write into an empty FIFO is visible on head
// in the same cycle, so BRAM data can be offered the cycle it returns.
module skid_fifo2 #(
  parameter int W = 13
) (
  input  logic         clock,
  input  logic         i_reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] m0, m1;
  logic [1:0]   cnt;
  logic         rd_ok;

  assign count = cnt;
  assign valid = (cnt != 2'd0) || wr_en;
  assign rd_ok = rd_en && valid;

  always_comb begin
    head = '0;
    if (cnt != 2'd0)
      head = m0;
    else if (wr_en)
      head = wr_data;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      m0  <= '0;
      m1  <= '0;
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: if (wr_en && !rd_ok) begin
          m0  <= wr_data;
          cnt <= 2'd1;
        end
        2'd1: begin
          if (wr_en && rd_ok) begin
            m0 <= wr_data;
          end else if (wr_en) begin
            m1  <= wr_data;
            cnt <= 2'd2;
          end else if (rd_ok) begin
            cnt <= 2'd0;
          end
        end
        default: if (rd_ok) begin
          m0 <= m1;
          if (wr_en) m1 <= wr_data;
          else       cnt <= 2'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bram_capture_reader.sv
// Plays captured FIR samples back from BRAM onto a valid/ready stream,
// absorbing the 1-cycle read latency and sink backpressure.
module bram_capture_reader
  import bram_capture_reader_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int DEPTH   = MAX_COUNT
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mem_full,
  output logic [NB_ADDR-1:0] o_read_addr,
  output logic               o_read_enable,
  input  logic [NB_DATA-1:0] i_read_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_ADDR:0] CNT_END  = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR:0] CNT_LAST = (NB_ADDR+1)'(DEPTH - 1);
  localparam logic [NB_ADDR:0] CNT_ONE  = (NB_ADDR+1)'(1);

  state_t           state, state_nxt;
  logic             start_q, start_edge, go;
  logic             in_flight, issue, accept, fifo_valid;
  logic [1:0]       occ;
  logic [NB_ADDR:0] issue_cnt, accept_cnt;

  assign start_edge = i_start & ~start_q;
  assign go         = (state == ST_IDLE) && start_edge && i_mem_full;

  // Occupancy plus the read in flight never exceeds the two FIFO slots.
  assign issue = (state == ST_STREAM) && (issue_cnt < CNT_END) &&
                 (({1'b0, occ} + {2'b00, in_flight}) < 3'd2);

  assign o_read_enable = issue;
  assign o_read_addr   = issue ? issue_cnt[NB_ADDR-1:0] : '0;
  assign o_valid       = fifo_valid;
  assign accept        = fifo_valid && i_ready;

  skid_fifo2 #(.W(NB_DATA)) u_fifo (
    .clock   (clock),
    .i_reset (i_reset),
    .wr_en   (in_flight),
    .wr_data (i_read_data),
    .rd_en   (i_ready),
    .head    (o_data),
    .valid   (fifo_valid),
    .count   (occ)
  );

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE:   if (go) state_nxt = ST_STREAM;
      ST_STREAM: begin
        o_busy = 1'b1;
        if (accept && accept_cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // start_q comes out of reset high so a switch left on through reset
  // does not look like a fresh edge.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b1;
      in_flight  <= 1'b0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
    end else begin
      state     <= state_nxt;
      start_q   <= i_start;
      in_flight <= issue;
      if (go) begin
        issue_cnt  <= '0;
        accept_cnt <= '0;
      end else begin
        if (issue)  issue_cnt  <= issue_cnt + CNT_ONE;
        if (accept) accept_cnt <= accept_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_reader.sv
// Directed bench: three reader instances (DEPTH=8, DEPTH=1, DEPTH=2^NB_ADDR)
// against BRAM models returning addr+100 one cycle after each read.
module tb_bram_capture_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, full, rnd_mode, rnd_bit, ready;
  logic start_a, start_b, start_c, clr_a;
  assign ready = rnd_mode ? rnd_bit : 1'b1;

  logic [10:0] ra_a;  logic re_a; logic [12:0] rd_a, dat_a; logic val_a, busy_a, done_a;
  logic [3:0]  ra_b;  logic re_b; logic [12:0] rd_b, dat_b; logic val_b, busy_b, done_b;
  logic [2:0]  ra_c;  logic re_c; logic [12:0] rd_c, dat_c; logic val_c, busy_c, done_c;

  bram_capture_reader #(.NB_ADDR(11), .NB_DATA(13), .DEPTH(8)) u_a (
    .clock(clock), .i_reset(rst), .i_start(start_a), .i_mem_full(full),
    .o_read_addr(ra_a), .o_read_enable(re_a), .i_read_data(rd_a),
    .o_data(dat_a), .o_valid(val_a), .i_ready(ready), .o_busy(busy_a), .o_done(done_a));

  bram_capture_reader #(.NB_ADDR(4), .NB_DATA(13), .DEPTH(1)) u_b (
    .clock(clock), .i_reset(rst), .i_start(start_b), .i_mem_full(full),
    .o_read_addr(ra_b), .o_read_enable(re_b), .i_read_data(rd_b),
    .o_data(dat_b), .o_valid(val_b), .i_ready(ready), .o_busy(busy_b), .o_done(done_b));

  bram_capture_reader #(.NB_ADDR(3), .NB_DATA(13), .DEPTH(8)) u_c (
    .clock(clock), .i_reset(rst), .i_start(start_c), .i_mem_full(full),
    .o_read_addr(ra_c), .o_read_enable(re_c), .i_read_data(rd_c),
    .o_data(dat_c), .o_valid(val_c), .i_ready(ready), .o_busy(busy_c), .o_done(done_c));

  always @(posedge clock) begin
    if (re_a) rd_a <= 13'(ra_a) + 13'd100;
    if (re_b) rd_b <= 13'(ra_b) + 13'd100;
    if (re_c) rd_c <= 13'(ra_c) + 13'd100;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Instance A monitor
  int iss_a, acc_a, ndone_a, nbusy_a, first_re_a, first_acc_a, last_acc_a, done_cyc_a;
  logic stall_a;
  logic [12:0] hold_a;
  always @(negedge clock) begin
    if (rst || clr_a) begin
      iss_a = 0; acc_a = 0; ndone_a = 0; nbusy_a = 0; stall_a = 1'b0;
      first_re_a = -1; first_acc_a = -1; last_acc_a = -1; done_cyc_a = -1;
    end else begin
      if (re_a) begin
        chk("a_outstanding_lt2", int'((iss_a - acc_a) < 2), 1);
        chk("a_addr", int'(ra_a), iss_a);
        if (iss_a == 0) first_re_a = cyc;
        iss_a++;
      end
      if (stall_a) begin
        chk("a_hold_valid", int'(val_a), 1);
        chk("a_hold_data", int'(dat_a), int'(hold_a));
      end
      if (val_a && ready) begin
        chk("a_data", int'(dat_a), 100 + acc_a);
        if (acc_a == 0) first_acc_a = cyc;
        last_acc_a = cyc;
        acc_a++;
      end
      if (done_a) begin ndone_a++; done_cyc_a = cyc; end
      if (busy_a) nbusy_a++;
      stall_a = val_a && !ready;
      hold_a  = dat_a;
    end
  end

  // Instances B and C monitor
  int iss_b, acc_b, ndone_b, done_cyc_b, iss_c, acc_c, ndone_c, done_cyc_c;
  always @(negedge clock) begin
    if (rst) begin
      iss_b = 0; acc_b = 0; ndone_b = 0; done_cyc_b = -1;
      iss_c = 0; acc_c = 0; ndone_c = 0; done_cyc_c = -1;
    end else begin
      if (re_b) begin chk("b_addr", int'(ra_b), iss_b); iss_b++; end
      if (val_b && ready) begin chk("b_data", int'(dat_b), 100 + acc_b); acc_b++; end
      if (done_b) begin ndone_b++; done_cyc_b = cyc; end
      if (re_c) begin chk("c_addr", int'(ra_c), iss_c); iss_c++; end
      if (val_c && ready) begin chk("c_data", int'(dat_c), 100 + acc_c); acc_c++; end
      if (done_c) begin ndone_c++; done_cyc_c = cyc; end
    end
  end

  task automatic clear_a();
    clr_a = 1'b1;
    @(negedge clock); #1;
    clr_a = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int s;
  logic found;

  initial begin
    rst = 1'b1; full = 1'b0; rnd_mode = 1'b0; clr_a = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_re", int'(re_a), 0);
    chk("rst_addr", int'(ra_a), 0);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_data", int'(dat_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    @(posedge clock); #1 rst = 1'b0;
    tick(2);

    // basic playback, timing relative to start cycle
    full = 1'b1;
    clear_a();
    start_a = 1'b1; s = cyc;
    tick(20);
    chk("basic_first_read", first_re_a, s + 1);
    chk("basic_first_accept", first_acc_a, s + 2);
    chk("basic_last_accept", last_acc_a, s + 9);
    chk("basic_done_cycle", done_cyc_a, s + 10);
    chk("basic_accepts", acc_a, 8);
    chk("basic_reads", iss_a, 8);
    chk("basic_done_count", ndone_a, 1);
    chk("basic_busy_cycles", nbusy_a, 10);
    chk("basic_idle_busy", int'(busy_a), 0);
    start_a = 1'b0;

    // random backpressure
    tick(2);
    clear_a();
    rnd_mode = 1'b1;
    start_a = 1'b1;
    tick(100);
    chk("bp_accepts", acc_a, 8);
    chk("bp_reads", iss_a, 8);
    chk("bp_done_count", ndone_a, 1);
    rnd_mode = 1'b0; start_a = 1'b0;

    // start ignored without mem_full
    tick(2);
    full = 1'b0;
    clear_a();
    start_a = 1'b1;
    tick(20);
    chk("nofull_reads", iss_a, 0);
    chk("nofull_busy", nbusy_a, 0);
    start_a = 1'b0; full = 1'b1;

    // start held 50 cycles: one playback
    tick(2);
    clear_a();
    start_a = 1'b1;
    tick(50);
    chk("held_accepts", acc_a, 8);
    chk("held_done_count", ndone_a, 1);
    start_a = 1'b0;

    // second edge mid-playback is ignored
    tick(2);
    clear_a();
    start_a = 1'b1;
    tick(3);
    start_a = 1'b0;
    tick(1);
    start_a = 1'b1;
    tick(30);
    chk("reedge_accepts", acc_a, 8);
    chk("reedge_reads", iss_a, 8);
    chk("reedge_done_count", ndone_a, 1);
    start_a = 1'b0;

    // reset after 3 acceptances
    tick(2);
    clear_a();
    start_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock); #2;
      if (acc_a == 3) found = 1'b1;
    end
    chk("midrst_reached_3", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("midrst_re", int'(re_a), 0);
    chk("midrst_addr", int'(ra_a), 0);
    chk("midrst_valid", int'(val_a), 0);
    chk("midrst_data", int'(dat_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_done", int'(done_a), 0);
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("midrst_no_autostart", iss_a, 0);
    chk("midrst_no_done", ndone_a, 0);
    start_a = 1'b0;
    tick(1);
    start_a = 1'b1;
    tick(20);
    chk("midrst_replay_accepts", acc_a, 8);
    chk("midrst_replay_done", ndone_a, 1);
    start_a = 1'b0;

    // DEPTH = 1
    tick(2);
    start_b = 1'b1; s = cyc;
    tick(10);
    chk("d1_reads", iss_b, 1);
    chk("d1_accepts", acc_b, 1);
    chk("d1_done_count", ndone_b, 1);
    chk("d1_done_cycle", done_cyc_b, s + 3);

    // DEPTH = 2^NB_ADDR, NB_ADDR = 3
    start_c = 1'b1; s = cyc;
    tick(20);
    chk("full_reads", iss_c, 8);
    chk("full_accepts", acc_c, 8);
    chk("full_done_count", ndone_c, 1);
    chk("full_done_cycle", done_cyc_c, s + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
